// File: rtl/ray_pixel_source.sv
// ray_pixel_source
// Raster pixel coordinate generator. On a start request it scans one frame of
// H_PIXELS x V_PIXELS pixels in raster order and presents each pixel as two
// independent AXI-Stream style beats: the column on the hcount stream and the
// row on the vcount stream. A pixel advances only once both of its beats have
// been accepted, so neither stream can get more than one pixel ahead.
//
// Ports
//   aclk                 rising-edge clock
//   areset               synchronous active-high reset
//   start                one-cycle frame request, honoured only in IDLE
//   abort                terminates the frame in progress (no frame_done)
//   hcount_axis_tdata    pixel column (11 bits)
//   hcount_axis_tvalid   column beat valid
//   hcount_axis_tready   downstream accepts the column beat
//   vcount_axis_tdata    pixel row (10 bits)
//   vcount_axis_tvalid   row beat valid
//   vcount_axis_tready   downstream accepts the row beat
//   busy                 high while a frame is being scanned
//   frame_done           one-cycle pulse after the last pixel completes
//
// Every output is taken straight from a flop, so nothing depends
// combinationally on either tready.

module ray_pixel_source #(
  parameter int H_PIXELS = 640,
  parameter int V_PIXELS = 360
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        start,
  input  logic        abort,
  output logic [10:0] hcount_axis_tdata,
  output logic        hcount_axis_tvalid,
  input  logic        hcount_axis_tready,
  output logic [9:0]  vcount_axis_tdata,
  output logic        vcount_axis_tvalid,
  input  logic        vcount_axis_tready,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [10:0] H_LAST = 11'(H_PIXELS - 1);
  localparam logic [9:0]  V_LAST = 10'(V_PIXELS - 1);

  logic [0:0]  state_r, state_s;
  logic [10:0] h_r, h_s;
  logic [9:0]  v_r, v_s;
  logic        hvalid_r, hvalid_s;
  logic        vvalid_r, vvalid_s;
  logic        done_r, done_s;

  logic        h_acc_s;
  logic        v_acc_s;
  logic        pix_done_s;
  logic        last_s;

  // Handshake decode for the current pixel.
  always_comb begin
    h_acc_s = hvalid_r & hcount_axis_tready;
    v_acc_s = vvalid_r & vcount_axis_tready;
    // A stream whose tvalid is already low has delivered its beat for this
    // pixel, so it counts as complete.
    pix_done_s = (h_acc_s | ~hvalid_r) & (v_acc_s | ~vvalid_r);
    last_s     = (h_r == H_LAST) && (v_r == V_LAST);
  end

  // Next-state logic for the scan controller.
  always_comb begin
    state_s  = state_r;
    h_s      = h_r;
    v_s      = v_r;
    hvalid_s = hvalid_r;
    vvalid_s = vvalid_r;
    done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        // A start landing on the frame_done cycle is dropped; abort wins
        // over start.
        if (start && !abort && !done_r) begin
          state_s  = RUN;
          h_s      = 11'd0;
          v_s      = 10'd0;
          hvalid_s = 1'b1;
          vvalid_s = 1'b1;
        end else begin
          hvalid_s = 1'b0;
          vvalid_s = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          state_s  = IDLE;
          h_s      = 11'd0;
          v_s      = 10'd0;
          hvalid_s = 1'b0;
          vvalid_s = 1'b0;
        end else if (pix_done_s) begin
          if (last_s) begin
            state_s  = IDLE;
            h_s      = 11'd0;
            v_s      = 10'd0;
            hvalid_s = 1'b0;
            vvalid_s = 1'b0;
            done_s   = 1'b1;
          end else begin
            if (h_r == H_LAST) begin
              h_s = 11'd0;
              v_s = v_r + 10'd1;
            end else begin
              h_s = h_r + 11'd1;
            end
            hvalid_s = 1'b1;
            vvalid_s = 1'b1;
          end
        end else begin
          // Only one beat done: that stream waits for its partner.
          hvalid_s = hvalid_r & ~h_acc_s;
          vvalid_s = vvalid_r & ~v_acc_s;
        end
      end
      default: begin
        state_s  = IDLE;
        h_s      = 11'd0;
        v_s      = 10'd0;
        hvalid_s = 1'b0;
        vvalid_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r  <= IDLE;
      h_r      <= 11'd0;
      v_r      <= 10'd0;
      hvalid_r <= 1'b0;
      vvalid_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      h_r      <= h_s;
      v_r      <= v_s;
      hvalid_r <= hvalid_s;
      vvalid_r <= vvalid_s;
      done_r   <= done_s;
    end
  end

  assign hcount_axis_tdata  = h_r;
  assign hcount_axis_tvalid = hvalid_r;
  assign vcount_axis_tdata  = v_r;
  assign vcount_axis_tvalid = vvalid_r;
  assign busy               = (state_r == RUN);
  assign frame_done         = done_r;

endmodule

// File: tb/tb_ray_pixel_source.sv
module tb_ray_pixel_source;

  logic aclk = 1'b0;
  logic areset;
  logic a_start, a_abort, a_hr, a_vr;
  logic b_start, b_abort, b_hr, b_vr;
  logic [10:0] a_hd, b_hd;
  logic [9:0]  a_vd, b_vd;
  logic a_hv, a_vv, a_busy, a_done;
  logic b_hv, b_vv, b_busy, b_done;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: per instance, count of accepted beats on each stream.
  int m_run[2];
  int m_h[2];
  int m_v[2];
  int m_done[2];
  int HP[2] = '{4, 1};
  int VP[2] = '{2, 1};

  always #5 aclk = ~aclk;

  ray_pixel_source #(.H_PIXELS(4), .V_PIXELS(2)) dut_a (
    .aclk(aclk), .areset(areset), .start(a_start), .abort(a_abort),
    .hcount_axis_tdata(a_hd), .hcount_axis_tvalid(a_hv), .hcount_axis_tready(a_hr),
    .vcount_axis_tdata(a_vd), .vcount_axis_tvalid(a_vv), .vcount_axis_tready(a_vr),
    .busy(a_busy), .frame_done(a_done)
  );

  ray_pixel_source #(.H_PIXELS(1), .V_PIXELS(1)) dut_b (
    .aclk(aclk), .areset(areset), .start(b_start), .abort(b_abort),
    .hcount_axis_tdata(b_hd), .hcount_axis_tvalid(b_hv), .hcount_axis_tready(b_hr),
    .vcount_axis_tdata(b_vd), .vcount_axis_tvalid(b_vv), .vcount_axis_tready(b_vr),
    .busy(b_busy), .frame_done(b_done)
  );

  function automatic int min2(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  // Expected {busy, hvalid, vvalid, frame_done, column, row}; data zeroed when not valid.
  function automatic logic [24:0] exp_vec(input int i);
    logic hv, vv;
    int hd, vd;
    hv = (m_run[i] != 0) && (m_h[i] <= m_v[i]);
    vv = (m_run[i] != 0) && (m_v[i] <= m_h[i]);
    hd = hv ? (m_h[i] % HP[i]) : 0;
    vd = vv ? (m_v[i] / HP[i]) : 0;
    return {(m_run[i] != 0), hv, vv, (m_done[i] != 0), 11'(hd), 10'(vd)};
  endfunction

  function automatic logic [24:0] obs_a();
    return {a_busy, a_hv, a_vv, a_done, (a_hv ? a_hd : 11'd0), (a_vv ? a_vd : 10'd0)};
  endfunction

  function automatic logic [24:0] obs_b();
    return {b_busy, b_hv, b_vv, b_done, (b_hv ? b_hd : 11'd0), (b_vv ? b_vd : 10'd0)};
  endfunction

  task automatic model_update(input int i, input logic rst, input logic st, input logic ab,
                              input logic hr, input logic vr);
    int p;
    int nd;
    int n;
    nd = 0;
    n  = HP[i] * VP[i];
    if (rst) begin
      m_run[i] = 0; m_h[i] = 0; m_v[i] = 0;
    end else if (m_run[i] != 0) begin
      if (ab) begin
        m_run[i] = 0;
      end else begin
        p = min2(m_h[i], m_v[i]);
        if (m_h[i] == p && hr) m_h[i]++;
        if (m_v[i] == p && vr) m_v[i]++;
        if (m_h[i] == n && m_v[i] == n) begin
          m_run[i] = 0;
          nd = 1;
        end
      end
    end else if (st && !ab && m_done[i] == 0) begin
      m_run[i] = 1; m_h[i] = 0; m_v[i] = 0;
    end
    m_done[i] = nd;
  endtask

  // Apply one cycle of inputs to both instances and advance the model.
  task automatic drive(input logic rst,
                       input logic sa, input logic aa, input logic hra, input logic vra,
                       input logic sb, input logic ab, input logic hrb, input logic vrb);
    areset = rst;
    a_start = sa; a_abort = aa; a_hr = hra; a_vr = vra;
    b_start = sb; b_abort = ab; b_hr = hrb; b_vr = vrb;
    model_update(0, rst, sa, aa, hra, vra);
    model_update(1, rst, sb, ab, hrb, vrb);
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_h[i] = 0; m_v[i] = 0; m_done[i] = 0;
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    if ({a_busy, a_hv, a_vv, a_done, a_hd, a_vd} !== 25'd0) begin
      miscompares++;
      $display("FAIL reset_a: got %h want 0", {a_busy, a_hv, a_vv, a_done, a_hd, a_vd});
    end
    vectors++;
    if ({b_busy, b_hv, b_vv, b_done, b_hd, b_vd} !== 25'd0) begin
      miscompares++;
      $display("FAIL reset_b: got %h want 0", {b_busy, b_hv, b_vv, b_done, b_hd, b_vd});
    end
    vectors++;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    if (obs_a() !== exp_vec(0)) begin
      miscompares++;
      $display("FAIL reset_idle: got %h want %h", obs_a(), exp_vec(0));
    end
    vectors++;
  endtask

  task automatic test_full_frame();
    int hv_cycles;
    int dones;
    hv_cycles = 0;
    dones = 0;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 14; c++) begin
      if (obs_a() !== exp_vec(0)) begin
        miscompares++;
        $display("FAIL full_frame c%0d: got %h want %h", c, obs_a(), exp_vec(0));
      end
      vectors++;
      if (a_hv === 1'b1) hv_cycles++;
      if (a_done === 1'b1) dones++;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    if (hv_cycles != 8) begin
      miscompares++;
      $display("FAIL full_frame_len: got %0d valid cycles want 8", hv_cycles);
    end
    vectors++;
    if (dones != 1) begin
      miscompares++;
      $display("FAIL full_frame_done: got %0d pulses want 1", dones);
    end
    vectors++;
  endtask

  task automatic test_stall();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 24; c++) begin
      if (obs_a() !== exp_vec(0)) begin
        miscompares++;
        $display("FAIL stall c%0d: got %h want %h", c, obs_a(), exp_vec(0));
      end
      vectors++;
      if (c < 10)
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      else
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    end
  endtask

  task automatic test_every_third();
    int hq[$];
    int vq[$];
    logic vr;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 40; c++) begin
      if (obs_a() !== exp_vec(0)) begin
        miscompares++;
        $display("FAIL every_third c%0d: got %h want %h", c, obs_a(), exp_vec(0));
      end
      vectors++;
      vr = ((c % 3) == 2);
      if (a_hv === 1'b1) hq.push_back(int'(a_hd));
      if (a_vv === 1'b1 && vr) vq.push_back(int'(a_vd));
      drive(1'b0, 1'b0, 1'b0, 1'b1, vr, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    if (hq.size() != 8 || vq.size() != 8) begin
      miscompares++;
      $display("FAIL every_third_count: got %0d/%0d beats want 8/8", hq.size(), vq.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (hq[k] != (k % 4) || vq[k] != (k / 4)) begin
          miscompares++;
          $display("FAIL every_third_seq k%0d: got (%0d,%0d) want (%0d,%0d)",
                   k, hq[k], vq[k], k % 4, k / 4);
        end
        vectors++;
      end
    end
    vectors++;
  endtask

  task automatic test_random();
    logic hr, vr;
    for (int f = 0; f < 3; f++) begin
      drive(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'b0, 1'b0, 1'b1, 1'b1);
      for (int c = 0; c < 150; c++) begin
        if (obs_a() !== exp_vec(0)) begin
          miscompares++;
          $display("FAIL random f%0d c%0d: got %h want %h", f, c, obs_a(), exp_vec(0));
        end
        vectors++;
        if (m_run[0] == 0 && m_done[0] == 0) break;
        hr = 1'($urandom_range(0, 1));
        vr = 1'($urandom_range(0, 1));
        drive(1'b0, 1'b0, 1'b0, hr, vr, 1'b0, 1'b0, 1'b1, 1'b1);
      end
    end
  endtask

  task automatic test_abort();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 20; c++) begin
      if (obs_a() !== exp_vec(0)) begin
        miscompares++;
        $display("FAIL abort_run c%0d: got %h want %h", c, obs_a(), exp_vec(0));
      end
      vectors++;
      if (m_run[0] != 0 && m_h[0] == 6 && m_v[0] == 6) begin
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        break;
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    for (int c = 0; c < 3; c++) begin
      if ({a_busy, a_hv, a_vv, a_done} !== 4'b0000) begin
        miscompares++;
        $display("FAIL abort_idle c%0d: got %b want 0000", c, {a_busy, a_hv, a_vv, a_done});
      end
      vectors++;
      // Second cycle: abort and start together in IDLE -- start must lose.
      drive(1'b0, (c == 1), (c == 1), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    if ({a_busy, a_hv, a_vv, a_hd, a_vd} !== {3'b111, 11'd0, 10'd0}) begin
      miscompares++;
      $display("FAIL abort_restart: got %h want restart at (0,0)", {a_busy, a_hv, a_vv, a_hd, a_vd});
    end
    vectors++;
    for (int c = 0; c < 12; c++) begin
      if (obs_a() !== exp_vec(0)) begin
        miscompares++;
        $display("FAIL abort_rerun c%0d: got %h want %h", c, obs_a(), exp_vec(0));
      end
      vectors++;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    end
  endtask

  task automatic test_reset_midframe();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    if ({a_busy, a_hv, a_vv, a_done, a_hd, a_vd} !== 25'd0) begin
      miscompares++;
      $display("FAIL midreset: got %h want 0", {a_busy, a_hv, a_vv, a_done, a_hd, a_vd});
    end
    vectors++;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    if ({a_busy, a_hv, a_vv, a_hd, a_vd} !== {3'b111, 11'd0, 10'd0}) begin
      miscompares++;
      $display("FAIL midreset_start: got %h want run at (0,0)", {a_busy, a_hv, a_vv, a_hd, a_vd});
    end
    vectors++;
    for (int c = 0; c < 12; c++) begin
      if (obs_a() !== exp_vec(0)) begin
        miscompares++;
        $display("FAIL midreset_run c%0d: got %h want %h", c, obs_a(), exp_vec(0));
      end
      vectors++;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 26; c++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      if (obs_a() !== exp_vec(0)) begin
        miscompares++;
        $display("FAIL back_to_back c%0d: got %h want %h", c, obs_a(), exp_vec(0));
      end
      vectors++;
    end
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    end
  endtask

  task automatic test_degenerate();
    for (int c = 0; c < 30; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (obs_b() !== exp_vec(1)) begin
        miscompares++;
        $display("FAIL degenerate c%0d: got %h want %h", c, obs_b(), exp_vec(1));
      end
      vectors++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_frame();
    test_stall();
    test_every_third();
    test_random();
    test_abort();
    test_reset_midframe();
    test_back_to_back();
    test_degenerate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ray_pixel_source.md
RAY_PIXEL_SOURCE -- requirements
Module: ray_pixel_source

Interface
REQ-001 Parameter H_PIXELS, default 640, horizontal pixels per frame (1..2048).
REQ-002 Parameter V_PIXELS, default 360, vertical pixels per frame (1..1024).
REQ-003 aclk  input  1  single clock; all logic on the rising edge.
REQ-004 areset  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle request to scan one frame; sampled in IDLE only.
REQ-006 abort  input  1  terminates the frame in progress.
REQ-007 hcount_axis_tdata  output  11  pixel column, unsigned.
REQ-008 hcount_axis_tvalid  output  1  column beat valid.
REQ-009 hcount_axis_tready  input  1  downstream accepts the column beat.
REQ-010 vcount_axis_tdata  output  10  pixel row, unsigned.
REQ-011 vcount_axis_tvalid  output  1  row beat valid.
REQ-012 vcount_axis_tready  input  1  downstream accepts the row beat.
REQ-013 busy  output  1  high in RUN.
REQ-014 frame_done  output  1  one-cycle pulse when the last pixel's beats are both accepted.

Function
REQ-015 The block shall have states IDLE and RUN.
REQ-016 In IDLE, start=1 shall load h=0, v=0, enter RUN next cycle, and raise both tvalids that cycle.
REQ-017 In RUN, hcount_axis_tdata shall equal h and vcount_axis_tdata shall equal v. Both shall stay stable while their tvalid is high and unaccepted.
REQ-018 Each stream shall be handshaken independently; a beat is accepted on a cycle with tvalid=1 and tready=1.
REQ-019 After its beat is accepted, a stream shall drop tvalid and hold it low until the other stream's beat for the same pixel is accepted. No stream shall run ahead by more than one pixel.
REQ-020 The pixel shall advance on the cycle in which the second beat is accepted, or both beats are accepted together. Both tvalids shall be high for the new pixel on the next cycle, with zero bubble cycles when both readies are held high.
REQ-021 Advance order is raster: h increments; when h=H_PIXELS-1, h wraps to 0 and v increments.
REQ-022 When the pixel at h=H_PIXELS-1, v=V_PIXELS-1 completes, the block shall assert frame_done for exactly that cycle+1, deassert both tvalids, and return to IDLE.
REQ-023 With both readies held at 1, a frame shall take exactly H_PIXELS*V_PIXELS cycles of tvalid, followed by frame_done on the cycle after the last handshake.
REQ-024 start while in RUN shall be ignored.
REQ-025 A start that coincides with the frame_done cycle shall be ignored. The earliest effective start is the first cycle in IDLE.
REQ-026 abort=1 in RUN shall force IDLE next cycle with tvalids low and no frame_done pulse, even if a beat is accepted that same cycle.
REQ-027 abort in IDLE shall have no effect. abort shall have priority over start in the same cycle.
REQ-028 Degenerate H_PIXELS=1 or V_PIXELS=1 shall scan correctly. H_PIXELS=V_PIXELS=1 shall yield one pixel and then frame_done.
REQ-029 No output shall depend combinationally on any tready input.

Reset
REQ-030 areset=1 on a rising edge shall force IDLE, h=0, v=0, both tvalids=0, busy=0, and frame_done=0, overriding start and abort.
REQ-031 A reset mid-frame shall discard the frame without a frame_done pulse. The block shall accept start on the first cycle after areset deasserts.

Verification
REQ-032 Defaults, both readies=1, one start pulse -> 230400 pixel pairs (0,0),(1,0)…(639,0),(0,1)…(639,359) on consecutive cycles, then one frame_done pulse, busy low afterwards.
REQ-033 H_PIXELS=4, V_PIXELS=2; hcount_tready=1 constantly while vcount_tready is high only every 3rd cycle -> hcount tvalid drops after each accept, column values 0,1,2,3,0,1,2,3 are each accepted exactly once, paired with rows 0,0,0,0,1,1,1,1, and no column runs ahead of its row.
REQ-034 H_PIXELS=4, V_PIXELS=2; both readies=0 for 10 cycles after start -> tdata stays (0,0) with both tvalids high throughout; readies then go to 1 -> scan resumes at (0,0) with no loss.
REQ-035 abort asserted on pixel (2,1) of a 4x2 frame with both readies=1 -> next cycle IDLE, tvalids=0, no frame_done; a following start restarts at (0,0).
REQ-036 areset pulsed mid-frame together with start=1 -> IDLE with all outputs 0; start one cycle after reset deassert -> frame begins at (0,0).
REQ-037 H_PIXELS=V_PIXELS=1 with start held high continuously -> one beat (0,0) per stream, frame_done, then a new frame begins on the first IDLE cycle after frame_done.
